req_ack_seq_master: RTL
=======================

Name: req_ack_seq_master

Overview:
- Parametrised successor of the single-shot req/ack bus master.
- On `start`, it issues N back-to-back write transactions over the req/ack bus to a strided address window. It then reads every location back and compares each word with the expected pattern.
- Reports mismatches, per-transaction ack timeouts and completion.
- Sits between test/control logic and any req/ack slave (memory model or register file).

Parameters:
- N, 4, number of locations written and then read per run; legal range 1..1024.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRIDE, 1, address increment between transactions; taken modulo 2^ADDR_W.
- SEED, 32'hA5A5_0000, XOR seed for the data pattern; truncated or zero-extended to DATA_W.
- TIMEOUT, 16, maximum cycles `req` may wait for `ack`; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first address of the run; sampled when `start` is accepted.
- ack  in  1  slave acknowledge; completes the current transaction on any edge where req=1 and ack=1.
- rdata  in  DATA_W  read data; valid only on the edge where a read is acked.
- req  out  1  transaction request.
- cmd  out  1  1=write, 0=read.
- wdata  out  DATA_W  write data; 0 during reads.
- addr  out  ADDR_W  transaction address.
- busy  out  1  high from `start` acceptance until DONE.
- done  out  1  one-cycle pulse at the end of a run (normal or aborted).
- err_cnt  out  $clog2(N+1)  read-compare mismatches in the last run; saturates at N.
- timeout  out  1  sticky; set on timeout abort, cleared by the next accepted `start`.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - req, cmd, busy, done, timeout = 0;
  - wdata, addr, err_cnt = 0;
  - index counter = 0.
  - All outputs are registered.
- Pattern:
  - addr(i) = base_addr + i*STRIDE, modulo 2^ADDR_W; wrap-around is silent.
  - pat(i) = addr(i) XOR SEED, resized to DATA_W (upper bits zeroed or truncated).
- States: IDLE, WRITE, READ, FIN.
- IDLE:
  - On `start`, capture base_addr, clear err_cnt and timeout, set i=0, busy=1.
  - Next cycle: state=WRITE, req=1, cmd=1, addr=addr(0), wdata=pat(0).
  - `start` while busy is ignored.
- Request stability:
  - req, cmd, addr and wdata are held stable until the edge on which ack=1.
  - ack while req=0 is ignored.
- WRITE, on ack:
  - If i<N-1: i++ and present write i+1 on the next cycle, req still 1 (back-to-back, no idle cycle).
  - If i=N-1: i=0, state=READ; next cycle present read 0 (cmd=0, wdata=0, addr=addr(0)), req stays 1.
- READ, on ack:
  - Compare rdata with pat(i); on mismatch, err_cnt++ (saturating).
  - If i<N-1: i++ and present the next read back-to-back.
  - If i=N-1: req=0, state=FIN.
- Ack latency:
  - Minimum latency is 1 cycle, so a slave holding ack=1 constantly yields one transaction per cycle.
  - N writes plus N reads with ack constantly 1: req is high for exactly 2N cycles.
- Timeout:
  - A wait counter resets at each new request and increments each cycle req=1 and ack=0.
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT without ack: req=0, timeout=1, state=FIN.
  - err_cnt keeps its partial value.
- FIN: done=1 for one cycle, busy=0, state=IDLE. err_cnt and timeout hold until the next `start`.
- N=1: one write then one read, still back-to-back.
- Reset mid-run: immediate return to IDLE with all outputs zero; the in-flight transaction is abandoned. The slave must tolerate req dropping without ack.
- start and ack on the same edge while in IDLE: ack is ignored, start is accepted.

Decomposition:
- Shared package `req_ack_pkg`:
  - state enum (IDLE/WRITE/READ/FIN);
  - CMD_WRITE=1'b1 and CMD_READ=1'b0 constants;
  - pattern function pat(addr, seed).
- Sub-module `ack_timeout_cnt`:
  - parameter TIMEOUT;
  - inputs: clk, rst, clear, waiting;
  - output: expired.

Test Plan:
- N=4, base=0x100, SEED default, slave memory model with ack held 1:
  - writes to 0x100..0x103 with wdata 0xA5A5_0100..0xA5A5_0103, then 4 reads;
  - req high for 8 cycles, done after the last read, err_cnt=0, timeout=0.
- Same run, slave returns rdata XOR 1 on read index 2 → err_cnt=1; other behaviour unchanged.
- ack asserted 3 cycles after each req (stall) → addr, wdata and cmd stable throughout each stall; err_cnt=0; run takes 8×4 cycles.
- TIMEOUT=16, slave never acks → req drops after 16 cycles in write 0; timeout=1, done pulses, err_cnt=0, busy=0.
- base=0xFFFF_FFFE, STRIDE=1, N=4 → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1; readback passes.
- rst=0 during read 1, then release and `start` again → all outputs 0 immediately at reset; second run completes cleanly with err_cnt=0 and timeout cleared.

Source files
------------

// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared FSM state, command encoding and data-pattern helper
//   for req_ack_seq_master and its sub-modules.
package req_ack_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;
    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;
    // Computed at 64 bits; callers resize the result to their data width.
    function automatic logic [63:0] pat(input logic [63:0] addr, input logic [63:0] seed);
        return addr ^ seed;
    endfunction
endpackage

// File: rtl/ack_timeout_cnt.sv
// ack_timeout_cnt: counts consecutive cycles a request waits for ack.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   clear   - restart the count (no request pending, or ack this cycle)
//   waiting - request pending without ack this cycle
//   expired - this edge is the TIMEOUT-th waiting edge; never set when TIMEOUT=0
module ack_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (waiting)
            cnt <= cnt + CW'(1);
    // Fires on the edge that would bring the count to TIMEOUT, so req is
    // high for exactly TIMEOUT cycles before it drops.
    assign expired = (TIMEOUT != 0) && waiting && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/req_ack_seq_master.sv
// req_ack_seq_master: writes N strided locations over req/ack, reads them back
//   and counts mismatches against the expected pattern.
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - run request, accepted only in IDLE
//   base_addr - first address, sampled on start
//   ack/rdata - slave handshake and read data
//   req/cmd/wdata/addr - registered request outputs, stable until ack
//   busy/done - run in progress / one-cycle end-of-run pulse
//   err_cnt   - saturating read mismatch count of the last run
//   timeout   - sticky ack-timeout abort flag
module req_ack_seq_master
    import req_ack_pkg::*;
#(
    parameter int          N       = 4,
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int          STRIDE  = 1,
    parameter logic [31:0] SEED    = 32'hA5A5_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   ack,
    input  logic [DATA_W-1:0]      rdata,
    output logic                   req,
    output logic                   cmd,
    output logic [DATA_W-1:0]      wdata,
    output logic [ADDR_W-1:0]      addr,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(N+1)-1:0] err_cnt,
    output logic                   timeout
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int EW = $clog2(N + 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [ADDR_W-1:0] base;
    logic              expired;
    logic              fire;
    logic              last;
    logic [ADDR_W-1:0] next_addr;

    function automatic logic [DATA_W-1:0] pat_of(input logic [ADDR_W-1:0] a);
        return DATA_W'(pat(64'(a), 64'(SEED)));
    endfunction

    assign fire      = req && ack;
    assign last      = idx == IW'(N - 1);
    assign next_addr = addr + ADDR_W'(STRIDE);

    ack_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!req || ack),
        .waiting (req && !ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            req     <= 1'b0;
            cmd     <= 1'b0;
            wdata   <= '0;
            addr    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base    <= base_addr;
                    err_cnt <= '0;
                    timeout <= 1'b0;
                    idx     <= '0;
                    busy    <= 1'b1;
                    req     <= 1'b1;
                    cmd     <= CMD_WRITE;
                    addr    <= base_addr;
                    wdata   <= pat_of(base_addr);
                    state   <= WRITE;
                end
                WRITE: if (fire) begin
                    if (last) begin
                        idx   <= '0;
                        cmd   <= CMD_READ;
                        wdata <= '0;
                        addr  <= base;
                        state <= READ;
                    end else begin
                        idx   <= idx + IW'(1);
                        addr  <= next_addr;
                        wdata <= pat_of(next_addr);
                    end
                end else if (expired) begin
                    req     <= 1'b0;
                    timeout <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= FIN;
                end
                READ: if (fire) begin
                    if (rdata != pat_of(addr) && err_cnt != EW'(N))
                        err_cnt <= err_cnt + EW'(1);
                    if (last) begin
                        req   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        idx  <= idx + IW'(1);
                        addr <= next_addr;
                    end
                end else if (expired) begin
                    req     <= 1'b0;
                    timeout <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= FIN;
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
